// File: rtl/comb_gate_pkg.sv
// Shared constants and reference functions for the comb_gate leaf primitive.
// Used by comb_gate_core (the combinational path) and comb_gate (the clocked wrapper).
package comb_gate_pkg;

    localparam int CNT_W_DEFAULT = 8;

    function automatic logic f_y(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

    // Each operand is widened before the add so the sum carries into bit 1.
    function automatic logic [1:0] f_pop(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage : comb_gate_pkg

// File: rtl/comb_gate_core.sv
// Purely combinational gate: Y = (A & B) | C and the population count of A, B, C.
// It has no clock and no reset, so X or Z on an input propagates to the outputs.
module comb_gate_core
    import comb_gate_pkg::*;
(
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic       Y,
    output logic [1:0] pop
);

    always_comb begin
        Y   = f_y(A, B, C);
        pop = f_pop(A, B, C);
    end

endmodule : comb_gate_core

// File: rtl/comb_gate.sv
// Clocked wrapper around comb_gate_core: registered Y plus an optional saturating
// counter of Y_q rising edges, built only when COMBGATE_EDGE_CNT_EN is defined.
module comb_gate
    import comb_gate_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             Y,
    output logic             Y_q,
    output logic [1:0]       pop,
    output logic [CNT_W-1:0] y_rise_cnt
);

    logic y_reg_d;
    logic y_reg_q;

    comb_gate_core u_core (
        .A   (A),
        .B   (B),
        .C   (C),
        .Y   (Y),
        .pop (pop)
    );

    always_comb begin
        y_reg_d = Y;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg_q <= 1'b0;
        end else begin
            y_reg_q <= y_reg_d;
        end
    end

    assign Y_q = y_reg_q;

`ifdef COMBGATE_EDGE_CNT_EN
    logic             y_q_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: cnt_d gets a default before the conditional so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (y_reg_q && !y_q_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // y_q_d lags Y_q by one edge, so a rise is counted one edge after Y_q goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_d <= 1'b0;
            cnt_q <= '0;
        end else begin
            y_q_d <= y_reg_q;
            cnt_q <= cnt_d;
        end
    end

    assign y_rise_cnt = cnt_q;
`else
    assign y_rise_cnt = '0;
`endif

endmodule : comb_gate

// File: tb/tb_comb_gate.sv
// Self-checking bench for comb_gate: truth-table sweep, latency, async reset,
// saturation (second instance with CNT_W = 2) and randomized stimulus against a model.
module tb_comb_gate;

    logic       clk;
    logic       rst_n;
    logic       A, B, C;
    logic       Y,  Y_q;
    logic [1:0] pop;
    logic [7:0] y_rise_cnt;
    logic       Y2, Y_q2;
    logic [1:0] pop2;
    logic [1:0] y_rise_cnt2;

    int checks = 0;
    int errors = 0;

    // Model state: Y value sampled at each rising edge since reset was released.
    bit y_hist[$];

    comb_gate #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
        .Y(Y), .Y_q(Y_q), .pop(pop), .y_rise_cnt(y_rise_cnt)
    );

    comb_gate #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
        .Y(Y2), .Y_q(Y_q2), .pop(pop2), .y_rise_cnt(y_rise_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_y(input logic [2:0] abc);
        logic [7:0] tab;
        tab = 8'hEA;
        return int'(tab[abc]);
    endfunction

    function automatic int ref_pop(input logic [2:0] abc);
        return int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
    endfunction

    function automatic int ref_yq();
        return (y_hist.size() == 0) ? 0 : int'(y_hist[$]);
    endfunction

    // Rises of Y_q whose detection edge has already occurred, saturated at 2^w - 1.
    function automatic int ref_cnt(input int w);
        int n = 0;
`ifdef COMBGATE_EDGE_CNT_EN
        for (int i = 0; i < y_hist.size() - 1; i++) begin
            if (y_hist[i] && (i == 0 || !y_hist[i-1])) n++;
        end
        if (n > (1 << w) - 1) n = (1 << w) - 1;
`endif
        return n;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, " Y_q"},        32'(Y_q),         32'(ref_yq()));
        check({tag, " Y_q2"},       32'(Y_q2),        32'(ref_yq()));
        check({tag, " cnt"},        32'(y_rise_cnt),  32'(ref_cnt(8)));
        check({tag, " cnt2"},       32'(y_rise_cnt2), 32'(ref_cnt(2)));
    endtask

    // One clock period: drive at the falling edge, check comb outputs, then take the rising edge.
    task automatic cycle(input logic [2:0] abc);
        @(negedge clk);
        {A, B, C} = abc;
        #1;
        check("Y comb",   32'(Y),    32'(ref_y(abc)));
        check("pop comb", 32'(pop),  32'(ref_pop(abc)));
        check("Y2 comb",  32'(Y2),   32'(ref_y(abc)));
        check("pre-edge", 32'(Y_q),  32'(ref_yq()));
        @(posedge clk);
        if (rst_n) y_hist.push_back(bit'(ref_y(abc)));
        #1;
        check_regs("post-edge");
    endtask

    // Called one step after a rising edge: asserts reset between edges and checks it took effect.
    task automatic do_reset(input logic [2:0] abc_during);
        #1;
        rst_n = 1'b0;
        y_hist.delete();
        #1;
        check("async rst Y_q",  32'(Y_q),         32'd0);
        check("async rst cnt",  32'(y_rise_cnt),  32'd0);
        check("async rst cnt2", 32'(y_rise_cnt2), 32'd0);
        cycle(abc_during);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] abc;
        logic       y;
        logic [1:0] pop;
    } vec_t;

    vec_t sweep[8];
    int   sat_exp[5];
    int   base;

    initial begin
        sweep[0] = '{3'b000, 1'b0, 2'd0};
        sweep[1] = '{3'b001, 1'b1, 2'd1};
        sweep[2] = '{3'b010, 1'b0, 2'd1};
        sweep[3] = '{3'b011, 1'b1, 2'd2};
        sweep[4] = '{3'b100, 1'b0, 2'd1};
        sweep[5] = '{3'b101, 1'b1, 2'd2};
        sweep[6] = '{3'b110, 1'b1, 2'd2};
        sweep[7] = '{3'b111, 1'b1, 2'd3};
`ifdef COMBGATE_EDGE_CNT_EN
        sat_exp = '{1, 2, 3, 3, 3};
`else
        sat_exp = '{0, 0, 0, 0, 0};
`endif

        rst_n = 1'b0;
        {A, B, C} = 3'b000;
        #2;
        check("reset Y_q", 32'(Y_q),        32'd0);
        check("reset cnt", 32'(y_rise_cnt), 32'd0);

        // Exhaustive sweep held in reset: comb outputs follow inputs, registers stay at zero.
        for (int i = 0; i < 8; i++) begin
            cycle(sweep[i].abc);
            check("sweep Y",   32'(Y),   32'(sweep[i].y));
            check("sweep pop", 32'(pop), 32'(sweep[i].pop));
        end
        #1;
        rst_n = 1'b1;

        // Register latency: Y_q one edge after the change, count one edge later.
        cycle(3'b000);
        cycle(3'b000);
        base = ref_cnt(8);
        cycle(3'b001);
        check("latency Y_q edge1", 32'(Y_q),        32'd1);
        check("latency cnt edge1", 32'(y_rise_cnt), 32'(base));
        cycle(3'b001);
`ifdef COMBGATE_EDGE_CNT_EN
        check("latency cnt edge2", 32'(y_rise_cnt), 32'(base + 1));
`else
        check("latency cnt edge2", 32'(y_rise_cnt), 32'd0);
`endif

        // Randomized stimulus against the model.
        for (int i = 0; i < 200; i++) begin
            cycle(3'($urandom_range(0, 7)));
        end

        // Reach count 5 with Y_q high, then reset between edges.
        do_reset(3'b000);
        for (int k = 0; k < 4; k++) begin
            cycle(3'b001);
            cycle(3'b001);
            cycle(3'b000);
            cycle(3'b000);
        end
        cycle(3'b001);
        cycle(3'b001);
        check("midop Y_q before rst", 32'(Y_q), 32'd1);
`ifdef COMBGATE_EDGE_CNT_EN
        check("midop cnt before rst", 32'(y_rise_cnt), 32'd5);
`else
        check("midop cnt before rst", 32'(y_rise_cnt), 32'd0);
`endif
        #1;
        rst_n = 1'b0;
        y_hist.delete();
        #1;
        check("midop rst Y_q", 32'(Y_q),        32'd0);
        check("midop rst cnt", 32'(y_rise_cnt), 32'd0);
        {A, B, C} = 3'b110;
        #1;
        check("midop Y in reset",   32'(Y),   32'd1);
        check("midop pop in reset", 32'(pop), 32'd2);
        {A, B, C} = 3'b000;
        #1;
        check("midop Y low in reset", 32'(Y), 32'd0);
        cycle(3'b000);
        #1;
        rst_n = 1'b1;

        // Saturation on the 2-bit counter instance.
        do_reset(3'b000);
        for (int k = 0; k < 5; k++) begin
            cycle(3'b001);
            cycle(3'b001);
            check($sformatf("sat cnt2 rise%0d", k + 1), 32'(y_rise_cnt2), 32'(sat_exp[k]));
            cycle(3'b000);
            cycle(3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_comb_gate
